// File: rtl/or_decode_pkg.sv
// or_decode_pkg: ORBIS32 opcodes, ALU sub-ops, load/store sizes and the decoded bundle type (DECODE_FPU_EN adds FPU fields)
package or_decode_pkg;
  localparam logic [5:0] OP_J     = 6'h00, OP_JAL   = 6'h01, OP_BNF  = 6'h03, OP_BF    = 6'h04;
  localparam logic [5:0] OP_NOP   = 6'h05, OP_MOVHI = 6'h06, OP_SYS  = 6'h08, OP_JR    = 6'h11;
  localparam logic [5:0] OP_JALR  = 6'h12, OP_LWZ   = 6'h21, OP_LWS  = 6'h22, OP_LBZ   = 6'h23;
  localparam logic [5:0] OP_LBS   = 6'h24, OP_LHZ   = 6'h25, OP_LHS  = 6'h26, OP_ADDI  = 6'h27;
  localparam logic [5:0] OP_ADDIC = 6'h28, OP_ANDI  = 6'h29, OP_ORI  = 6'h2A, OP_MFSPR = 6'h2D;
  localparam logic [5:0] OP_SFI   = 6'h2F, OP_MTSPR = 6'h30, OP_FPU  = 6'h32, OP_SW    = 6'h35;
  localparam logic [5:0] OP_SB    = 6'h36, OP_SH    = 6'h37, OP_ALU  = 6'h38, OP_SF    = 6'h39;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_ADDC = 4'h1, ALU_SUB = 4'h2;
  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  typedef struct packed {
    logic [4:0]  ra, rb, rd;
    logic [31:0] imm;
    logic        alu_sub, alu_en_carry, mtspr, mfspr, set_flg, load, store, ldst_zero_ext;
    logic [1:0]  ldst_size;
    logic        ill, sys, trap;
`ifdef DECODE_FPU_EN
    logic        fpu;
    logic [7:0]  fpu_op;
`endif
  } dec_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/or_decode_pipe_if.sv
// or_decode_pipe_if: fetch-side push, flush and decoded-bundle handshake (DECODE_FPU_EN adds FPU outputs)
interface or_decode_pipe_if #(parameter int PC_W = 32);
  logic            flush_in, inst_valid_in, inst_ready_out, dec_valid_out, dec_ready_in;
  logic [31:0]     inst_in, imm_out;
  logic [PC_W-1:0] pc_in, pc_out;
  logic [4:0]      reg_a_addr_out, reg_b_addr_out, reg_d_addr_out;
  logic            ctl_alu_sub_out, ctl_alu_en_carry_out, ctl_mtspr_out, ctl_mfspr_out;
  logic            ctl_set_flg_out, ctl_load_out, ctl_store_out, ctl_ldst_zero_ext_out;
  logic [1:0]      ctl_ldst_size_out;
  logic            flag_ill_inst_out, flag_syscall_out, flag_trap_out;
`ifdef DECODE_FPU_EN
  logic            ctl_fpu_out;
  logic [7:0]      fpu_op_out;
`endif
  modport master (
`ifdef DECODE_FPU_EN
    input ctl_fpu_out, fpu_op_out,
`endif
    output flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
    input inst_ready_out, dec_valid_out, pc_out, reg_a_addr_out, reg_b_addr_out, reg_d_addr_out, imm_out,
    input ctl_alu_sub_out, ctl_alu_en_carry_out, ctl_mtspr_out, ctl_mfspr_out, ctl_set_flg_out,
    input ctl_load_out, ctl_store_out, ctl_ldst_zero_ext_out, ctl_ldst_size_out,
    input flag_ill_inst_out, flag_syscall_out, flag_trap_out
  );
  modport slave (
`ifdef DECODE_FPU_EN
    output ctl_fpu_out, fpu_op_out,
`endif
    input flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
    output inst_ready_out, dec_valid_out, pc_out, reg_a_addr_out, reg_b_addr_out, reg_d_addr_out, imm_out,
    output ctl_alu_sub_out, ctl_alu_en_carry_out, ctl_mtspr_out, ctl_mfspr_out, ctl_set_flg_out,
    output ctl_load_out, ctl_store_out, ctl_ldst_zero_ext_out, ctl_ldst_size_out,
    output flag_ill_inst_out, flag_syscall_out, flag_trap_out
  );
endinterface

// File: rtl/or_decode_fifo.sv
// or_decode_fifo: synchronous instruction queue with push/pop/flush; flush wins over push and pop
module or_decode_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_q];
  // pointers wrap naturally; flush returns everything to empty
  always_comb begin
    wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: occupancy alone says which entries are live
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/or_decode_pipe.sv
// or_decode_pipe: queued ORBIS32 decode with registered valid/ready output; DECODE_FPU_EN makes lf.* legal
module or_decode_pipe
  import or_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic clk_in,
  input logic reset_in,
  or_decode_pipe_if.slave bus
);
  logic [31+PC_W:0] head;
  logic [31:0]      ir;
  logic [5:0]       op;
  logic             full, empty, pop, load;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  dec_t             dec, dec_q, dec_d;
  or_decode_fifo #(.DEPTH(DEPTH), .W(32 + PC_W)) u_fifo (
    .clk_in(clk_in), .reset_in(reset_in), .flush_i(bus.flush_in),
    .push_i(bus.inst_valid_in), .pop_i(pop), .data_i({bus.pc_in, bus.inst_in}),
    .data_o(head), .full_o(full), .empty_o(empty)
  );
  assign ir  = head[31:0];
  assign op  = ir[31:26];
  assign pop = !empty && (!valid_q || bus.dec_ready_in);
  assign bus.inst_ready_out = !full;
  // decode of the queue head; illegal encodings leave every control line low
  always_comb begin
    dec    = '0;
    dec.ra = ir[20:16];
    dec.rb = ir[15:11];
    dec.rd = ir[25:21];
    case (op)
      OP_ALU: begin
        dec.alu_en_carry = ir[3:0] == ALU_ADDC;
        dec.alu_sub      = ir[3:0] == ALU_SUB;
        dec.ill          = ir[3:0] > ALU_SUB;
      end
      OP_ADDI: dec.imm = sext16(ir[15:0]);
      OP_ADDIC: begin
        dec.imm          = sext16(ir[15:0]);
        dec.alu_en_carry = 1'b1;
      end
      OP_LWZ, OP_LWS, OP_LBZ, OP_LBS, OP_LHZ, OP_LHS: begin
        dec.imm           = sext16(ir[15:0]);
        dec.load          = 1'b1;
        dec.ldst_zero_ext = op == OP_LWZ || op == OP_LBZ || op == OP_LHZ;
        dec.ldst_size     = (op == OP_LWZ || op == OP_LWS) ? SZ_WORD :
                            (op == OP_LBZ || op == OP_LBS) ? SZ_BYTE : SZ_HALF;
      end
      OP_SW, OP_SB, OP_SH: begin
        dec.imm       = {{16{ir[25]}}, ir[25:21], ir[10:0]};
        dec.store     = 1'b1;
        dec.ldst_size = op == OP_SW ? SZ_WORD : op == OP_SB ? SZ_BYTE : SZ_HALF;
      end
      OP_MTSPR: dec.mtspr = 1'b1;
      OP_MFSPR: dec.mfspr = 1'b1;
      OP_SF:    dec.set_flg = 1'b1;
      OP_SFI: begin
        dec.imm     = sext16(ir[15:0]);
        dec.set_flg = 1'b1;
      end
      OP_ANDI, OP_ORI: dec.imm = {16'h0, ir[15:0]};
      OP_MOVHI: dec.imm = {ir[15:0], 16'h0};
      OP_J, OP_JAL, OP_BNF, OP_BF: dec.imm = {{4{ir[25]}}, ir[25:0], 2'b00};
      OP_NOP, OP_JR, OP_JALR: ;
      OP_SYS: begin
        dec.sys  = ir[25:16] == 10'h000;
        dec.trap = ir[25:16] == 10'h100;
        dec.ill  = !(dec.sys || dec.trap);
      end
`ifdef DECODE_FPU_EN
      OP_FPU: begin
        dec.fpu    = ir[7:4] == 4'h0;
        dec.fpu_op = dec.fpu ? ir[7:0] : 8'h0;
        dec.ill    = !dec.fpu;
      end
`endif
      default: dec.ill = 1'b1;
    endcase
  end
  // output stage: flush drops the bundle, pop loads a new one, consumption empties it
  always_comb begin
    load    = pop && !bus.flush_in;
    valid_d = bus.flush_in ? 1'b0 : pop ? 1'b1 : valid_q && !bus.dec_ready_in;
    dec_d   = load ? dec : dec_q;
    pc_d    = load ? head[31+PC_W:32] : pc_q;
  end
  // output registers; reset also clears the held bundle
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
    end
  end
  assign bus.dec_valid_out         = valid_q;
  assign bus.pc_out                = pc_q;
  assign bus.reg_a_addr_out        = dec_q.ra;
  assign bus.reg_b_addr_out        = dec_q.rb;
  assign bus.reg_d_addr_out        = dec_q.rd;
  assign bus.imm_out               = dec_q.imm;
  assign bus.ctl_alu_sub_out       = dec_q.alu_sub;
  assign bus.ctl_alu_en_carry_out  = dec_q.alu_en_carry;
  assign bus.ctl_mtspr_out         = dec_q.mtspr;
  assign bus.ctl_mfspr_out         = dec_q.mfspr;
  assign bus.ctl_set_flg_out       = dec_q.set_flg;
  assign bus.ctl_load_out          = dec_q.load;
  assign bus.ctl_store_out         = dec_q.store;
  assign bus.ctl_ldst_zero_ext_out = dec_q.ldst_zero_ext;
  assign bus.ctl_ldst_size_out     = dec_q.ldst_size;
  assign bus.flag_ill_inst_out     = dec_q.ill;
  assign bus.flag_syscall_out      = dec_q.sys;
  assign bus.flag_trap_out         = dec_q.trap;
`ifdef DECODE_FPU_EN
  assign bus.ctl_fpu_out           = dec_q.fpu;
  assign bus.fpu_op_out            = dec_q.fpu_op;
`endif
endmodule

// File: tb/tb_or_decode_pipe.sv
// tb_or_decode_pipe: queue-level model plus per-cycle compare and hand-computed directed checks
module tb_or_decode_pipe;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  or_decode_pipe_if #(.PC_W(PC_W)) bus ();
  or_decode_pipe #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk_in(clk), .reset_in(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  logic [9:0] ctl_v;
  logic [2:0] flg_v;
  assign ctl_v = {bus.ctl_alu_sub_out, bus.ctl_alu_en_carry_out, bus.ctl_mtspr_out, bus.ctl_mfspr_out,
                  bus.ctl_set_flg_out, bus.ctl_load_out, bus.ctl_store_out, bus.ctl_ldst_zero_ext_out,
                  bus.ctl_ldst_size_out};
  assign flg_v = {bus.flag_ill_inst_out, bus.flag_syscall_out, bus.flag_trap_out};
  typedef struct packed {
    logic [4:0]  ra, rb, rd;
    logic [31:0] imm;
    logic [9:0]  ctl;
    logic [2:0]  flg;
    logic        fpu;
    logic [7:0]  fop;
  } exp_t;
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int op, sub4, s16, s_st, s_j;
    bit alu, ld, st, sys, trap, fp, legal;
    logic [1:0] sz;
    op    = int'(w[31:26]);
    sub4  = int'(w[3:0]);
    alu   = op == 56;
    ld    = op >= 33 && op <= 38;
    st    = op >= 53 && op <= 55;
    sys   = op == 8 && w[25:16] == 10'h000;
    trap  = op == 8 && w[25:16] == 10'h100;
    fp    = 1'b0;
`ifdef DECODE_FPU_EN
    fp    = op == 50 && w[7:0] < 8'd16;
`endif
    legal = (op inside {0, 1, 3, 4, 5, 6, 17, 18, 39, 40, 41, 42, 45, 47, 48, 57}) || ld || st ||
            (alu && sub4 < 3) || sys || trap || fp;
    s16   = int'($signed(w[15:0]));
    s_st  = int'($signed({w[25:21], w[10:0]}));
    s_j   = int'($signed(w[25:0])) * 4;
    e     = '0;
    e.ra  = w[20:16];
    e.rb  = w[15:11];
    e.rd  = w[25:21];
    if ((op inside {39, 40, 47}) || ld) e.imm = s16;
    else if (op inside {41, 42}) e.imm = {16'h0, w[15:0]};
    else if (st) e.imm = s_st;
    else if (op == 6) e.imm = {w[15:0], 16'h0};
    else if (op inside {0, 1, 3, 4}) e.imm = s_j;
    sz = ld ? (op <= 34 ? 2'd2 : op <= 36 ? 2'd0 : 2'd1) : st ? (op == 53 ? 2'd2 : op == 54 ? 2'd0 : 2'd1) : 2'd0;
    e.ctl = {alu && sub4 == 2, (alu && sub4 == 1) || op == 40, op == 48, op == 45, op == 57 || op == 47,
             ld, st, ld && w[26], sz};
    if (!legal) e.ctl = '0;
    e.flg = {!legal, sys, trap};
    e.fpu = fp;
    e.fop = fp ? w[7:0] : 8'h0;
    return e;
  endfunction
  logic [63:0] mq[$];
  logic [63:0] out_it;
  bit          out_v = 1'b0;
  always @(posedge clk) begin
    bit acc;
    if (rst || bus.flush_in) begin
      mq.delete();
      out_v = 1'b0;
    end else begin
      acc = bus.inst_valid_in && mq.size() < DEPTH;
      if (mq.size() > 0 && (!out_v || bus.dec_ready_in)) begin
        out_it = mq.pop_front();
        out_v  = 1'b1;
      end else if (out_v && bus.dec_ready_in) out_v = 1'b0;
      if (acc) mq.push_back({bus.pc_in, bus.inst_in});
    end
  end
  always @(negedge clk) begin
    exp_t e;
    chk("ready", bus.inst_ready_out, mq.size() < DEPTH);
    chk("valid", bus.dec_valid_out, out_v);
    if (out_v) begin
      e = model(out_it[31:0]);
      chk("pc", bus.pc_out, out_it[63:32]);
      chk("imm", bus.imm_out, e.imm);
      chk("regs", {bus.reg_a_addr_out, bus.reg_b_addr_out, bus.reg_d_addr_out}, {e.ra, e.rb, e.rd});
      chk("ctl", ctl_v, e.ctl);
      chk("flags", flg_v, e.flg);
`ifdef DECODE_FPU_EN
      chk("fpu", {bus.ctl_fpu_out, bus.fpu_op_out}, {e.fpu, e.fop});
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic one(input logic [31:0] w, input logic [31:0] p);
    bus.inst_valid_in = 1'b1;
    bus.inst_in       = w;
    bus.pc_in         = p;
    step();
    bus.inst_valid_in = 1'b0;
    step();
  endtask
  logic [31:0] lit_w [5] = '{32'h03FFFFFF, 32'hD7E007FF, 32'h18A0ABCD, 32'hA8208001, 32'hBC00FFFF};
  logic [31:0] lit_i [5] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 32'hABCD0000, 32'h00008001, 32'hFFFFFFFF};
  logic [31:0] mix [24] = '{32'h9C000007, 32'hE0000001, 32'hE0000003, 32'hA0400010, 32'h8C000001,
                            32'h90000002, 32'h94000003, 32'h98000004, 32'h88000005, 32'hD8000000,
                            32'hDC000000, 32'hC0000000, 32'hB4000000, 32'hE4000000, 32'hBC00FFFF,
                            32'h15000000, 32'h44000000, 32'h48000000, 32'h10000010, 32'h0C000010,
                            32'h04000001, 32'h20010000, 32'hC80000FF, 32'hA4000000};
  initial begin
    int acc, i, guard;
    bus.flush_in = 1'b0;
    bus.inst_valid_in = 1'b0;
    bus.inst_in = '0;
    bus.pc_in = '0;
    bus.dec_ready_in = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", bus.dec_valid_out, 1'b0);
    chk("rst_ready", bus.inst_ready_out, 1'b1);
    chk("rst_imm", bus.imm_out, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_flags", {ctl_v, flg_v}, 13'h0);
    one(32'h9C21FFFC, 32'h100);
    chk("addi_valid", bus.dec_valid_out, 1'b1);
    chk("addi_regs", {bus.reg_d_addr_out, bus.reg_a_addr_out}, {5'd1, 5'd1});
    chk("addi_imm", bus.imm_out, 32'hFFFFFFFC);
    chk("addi_pc", bus.pc_out, 32'h100);
    chk("addi_flags", flg_v, 3'b000);
    bus.inst_valid_in = 1'b1;
    bus.inst_in = 32'hE0641002;
    bus.pc_in = 32'h104;
    step();
    bus.inst_in = 32'h84A30008;
    bus.pc_in = 32'h108;
    step();
    bus.inst_valid_in = 1'b0;
    chk("sub_ctl", {bus.ctl_alu_sub_out, bus.ctl_load_out}, 2'b10);
    step();
    chk("lwz_ctl", {bus.ctl_load_out, bus.ctl_ldst_size_out, bus.ctl_ldst_zero_ext_out}, 4'b1101);
    chk("lwz_imm", bus.imm_out, 32'h8);
    step();
    bus.dec_ready_in = 1'b0;
    acc = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      bus.inst_valid_in = 1'b1;
      bus.inst_in = 32'h9C000001 + k;
      bus.pc_in = 32'h200 + 4 * k;
      if (bus.inst_ready_out) acc++;
      step();
    end
    bus.inst_valid_in = 1'b0;
    chk("bp_accepted", acc, DEPTH + 1);
    chk("bp_ready", bus.inst_ready_out, 1'b0);
    chk("bp_hold_imm", bus.imm_out, 32'h1);
    chk("bp_hold_pc", bus.pc_out, 32'h200);
    bus.dec_ready_in = 1'b1;
    step();
    chk("bp_order", bus.pc_out, 32'h204);
    repeat (DEPTH + 1) step();
    one(32'h20000000, 32'h300);
    chk("sys_flag", flg_v, 3'b010);
    one(32'h21000000, 32'h304);
    chk("trap_flag", flg_v, 3'b001);
    one(32'hFC000000, 32'h308);
    chk("ill_flag", {flg_v, ctl_v}, {3'b100, 10'h0});
    bus.dec_ready_in = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      bus.inst_valid_in = 1'b1;
      bus.inst_in = 32'h9C000100 + k;
      bus.pc_in = 32'h400 + 4 * k;
      step();
    end
    bus.flush_in = 1'b1;
    bus.inst_in = 32'h9C000FFF;
    bus.pc_in = 32'h4FC;
    step();
    bus.flush_in = 1'b0;
    bus.inst_valid_in = 1'b0;
    chk("fl_valid", bus.dec_valid_out, 1'b0);
    chk("fl_ready", bus.inst_ready_out, 1'b1);
    bus.dec_ready_in = 1'b1;
    repeat (3) begin
      step();
      chk("fl_empty", bus.dec_valid_out, 1'b0);
    end
    one(32'hC8000003, 32'h500);
`ifdef DECODE_FPU_EN
    chk("fpu_ctl", {bus.ctl_fpu_out, bus.fpu_op_out, flg_v}, {1'b1, 8'h03, 3'b000});
`else
    chk("fpu_ill", flg_v, 3'b100);
`endif
    for (int k = 0; k < 5; k++) begin
      one(lit_w[k], 32'h600 + 4 * k);
      chk("lit_imm", bus.imm_out, lit_i[k]);
    end
    i = 0;
    guard = 0;
    while (i < 24 && guard < 400) begin
      bus.inst_valid_in = 1'b1;
      bus.inst_in = mix[i];
      bus.pc_in = 32'h700 + 4 * i;
      bus.dec_ready_in = 1'($urandom_range(0, 1));
      if (bus.inst_ready_out) i++;
      step();
      guard++;
    end
    chk("mix_done", i, 24);
    bus.inst_valid_in = 1'b0;
    bus.dec_ready_in = 1'b1;
    repeat (DEPTH + 2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_clear", {bus.dec_valid_out, bus.imm_out, ctl_v, flg_v}, 46'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
